// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard scoreboard.
// Holds the scoreboard entry struct, regfile select code and SELW helper.
package hazard_pkg;

  // Storage width for register numbers; REG_AW must not exceed it.
  localparam int RN_W = 8;

  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic            valid;
    logic            wreg;
    logic [RN_W-1:0] rn;
    logic            load;
  } entry_t;

  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-match search for one source operand.
// Ports: sb (stages 1..NT), src/use_src in; idx (stage k or 0), hazard out.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NT       = 2,
  parameter int LOAD_DLY = 1,
  parameter int SELW     = 2
) (
  input  entry_t [NT-1:0]    sb,
  input  logic [REG_AW-1:0]  src,
  input  logic               use_src,
  output logic [SELW-1:0]    idx,
  output logic               hazard
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    idx    = SELW'(FWD_REGFILE);
    hazard = 1'b0;
    if (use_src && src != '0) begin
      for (int k = NT; k >= 1; k--) begin
        if (sb[k-1].valid && sb[k-1].wreg &&
            sb[k-1].rn == RN_W'(src)) begin
          idx    = SELW'(k);
          hazard = sb[k-1].load && (k < 1 + LOAD_DLY);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use stall, ID handshake and EXE forwarding selects.
// Ports: clock/reset, ID operand info, mem_hold in; id_ready, stall,
// fwd_a/fwd_b, ex_valid out. HAZARD_PERF_EN adds stall_cnt/fwd_cnt.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_STG  = 3,
  parameter int LOAD_DLY = 1,
  parameter int SELW     = sel_w(NUM_STG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_load,
  input  logic              mem_hold,
  output logic              id_ready,
  output logic              stall,
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b,
  output logic              ex_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  // The WB entry is never matched (write-through covers it), so only
  // stages 1..NUM_STG-1 are stored; WB retirement is the shift out of NT.
  localparam int NT = NUM_STG - 1;

  entry_t [NT-1:0] sb_q, sb_d;
  logic [SELW-1:0] fwd_a_q, fwd_a_d;
  logic [SELW-1:0] fwd_b_q, fwd_b_d;
  logic [SELW-1:0] sel_a, sel_b;
  logic            haz_a, haz_b;

  hazard_match #(
    .REG_AW(REG_AW), .NT(NT), .LOAD_DLY(LOAD_DLY), .SELW(SELW)
  ) u_match_a (
    .sb(sb_q), .src(id_rs), .use_src(id_use_rs),
    .idx(sel_a), .hazard(haz_a)
  );

  hazard_match #(
    .REG_AW(REG_AW), .NT(NT), .LOAD_DLY(LOAD_DLY), .SELW(SELW)
  ) u_match_b (
    .sb(sb_q), .src(id_rt), .use_src(id_use_rt),
    .idx(sel_b), .hazard(haz_b)
  );

  assign stall    = id_valid & (haz_a | haz_b);
  assign id_ready = id_valid & ~stall & ~mem_hold;

  always_comb begin
    sb_d    = sb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!mem_hold) begin
      for (int k = NT - 1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0] = '0;
      fwd_a_d = SELW'(FWD_REGFILE);
      fwd_b_d = SELW'(FWD_REGFILE);
      if (id_ready) begin
        sb_d[0] = '{valid: 1'b1, wreg: id_wreg,
                    rn: RN_W'(id_rd), load: id_load};
        fwd_a_d = sel_a;
        fwd_b_d = sel_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      sb_q    <= sb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;
  assign ex_valid = sb_q[0].valid;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !mem_hold) stall_cnt_d = stall_cnt_q + 32'd1;
    if (id_ready && (sel_a != '0 || sel_b != '0))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed + random check of two scoreboard configs
// (3 stages/1 load delay and 4 stages/2 load delays) against a timeline model.
module tb_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_wreg = 1'b0, id_load = 1'b0, mem_hold = 1'b0;

  logic       ready0, stall0, exv0;
  logic [1:0] fa0, fb0;
  logic       ready1, stall1, exv1;
  logic [2:0] fa1, fb1;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clock = ~clock;

  hazard_scoreboard u0 (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rd(id_rd), .id_load(id_load),
    .mem_hold(mem_hold), .id_ready(ready0), .stall(stall0),
    .fwd_a(fa0), .fwd_b(fb0), .ex_valid(exv0)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc0), .fwd_cnt(fc0)
`endif
  );

  hazard_scoreboard #(.NUM_STG(4), .LOAD_DLY(2)) u1 (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rd(id_rd), .id_load(id_load),
    .mem_hold(mem_hold), .id_ready(ready1), .stall(stall1),
    .fwd_a(fa1), .fwd_b(fb1), .ex_valid(exv1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc1), .fwd_cnt(fc1)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Model: each issued instruction remembers the advance count at which it
  // entered EXE; its stage is (advances since then) + 1.
  int          NS [2] = '{3, 4};
  int          LD [2] = '{1, 2};
  int unsigned T  [2];
  bit          hv [2][8];
  bit          hw [2][8];
  bit          hl [2][8];
  int          hrd[2][8];
  int unsigned ht [2][8];
  int          hp [2];
  int          efa[2], efb[2];
  bit          eexv[2];
  int unsigned esc[2], efc[2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_clear(int i);
    for (int j = 0; j < 8; j++) hv[i][j] = 1'b0;
    efa[i] = 0; efb[i] = 0; eexv[i] = 1'b0;
    esc[i] = 0; efc[i] = 0;
  endtask

  task automatic lookup(int i, int src, bit u, output int k, output bit ld);
    int unsigned best;
    int unsigned st;
    k = 0; ld = 1'b0; best = 0;
    if (u && src != 0) begin
      for (int j = 0; j < 8; j++) begin
        st = T[i] - ht[i][j] + 1;
        if (hv[i][j] && hw[i][j] && hrd[i][j] == src &&
            st <= NS[i] - 1 && (k == 0 || ht[i][j] > best)) begin
          best = ht[i][j]; k = int'(st); ld = hl[i][j];
        end
      end
    end
  endtask

  task automatic model_comb(int i, output bit st, output bit rdy,
                            output int ka, output int kb);
    bit la, lb;
    lookup(i, int'(id_rs), id_use_rs, ka, la);
    lookup(i, int'(id_rt), id_use_rt, kb, lb);
    st  = id_valid && ((la && ka < 1 + LD[i]) || (lb && kb < 1 + LD[i]));
    rdy = id_valid && !st && !mem_hold;
  endtask

  task automatic model_update(int i, bit st, bit rdy, int ka, int kb);
    if (reset) begin
      model_clear(i);
    end else begin
      if (st && !mem_hold) esc[i]++;
      if (rdy && (ka != 0 || kb != 0)) efc[i]++;
      if (!mem_hold) begin
        T[i]++;
        if (rdy) begin
          hv[i][hp[i]] = 1'b1; hw[i][hp[i]] = id_wreg;
          hl[i][hp[i]] = id_load; hrd[i][hp[i]] = int'(id_rd);
          ht[i][hp[i]] = T[i];
          hp[i] = (hp[i] + 1) % 8;
          efa[i] = ka; efb[i] = kb; eexv[i] = 1'b1;
        end else begin
          efa[i] = 0; efb[i] = 0; eexv[i] = 1'b0;
        end
      end
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance.
  task automatic step();
    bit st, rdy;
    int ka, kb;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      model_comb(i, st, rdy, ka, kb);
      chk($sformatf("u%0d.stall", i),
          i == 0 ? 32'(stall0) : 32'(stall1), 32'(st));
      chk($sformatf("u%0d.id_ready", i),
          i == 0 ? 32'(ready0) : 32'(ready1), 32'(rdy));
      chk($sformatf("u%0d.fwd_a", i),
          i == 0 ? 32'(fa0) : 32'(fa1), 32'(efa[i]));
      chk($sformatf("u%0d.fwd_b", i),
          i == 0 ? 32'(fb0) : 32'(fb1), 32'(efb[i]));
      chk($sformatf("u%0d.ex_valid", i),
          i == 0 ? 32'(exv0) : 32'(exv1), 32'(eexv[i]));
`ifdef HAZARD_PERF_EN
      chk($sformatf("u%0d.stall_cnt", i), i == 0 ? sc0 : sc1, esc[i]);
      chk($sformatf("u%0d.fwd_cnt", i), i == 0 ? fc0 : fc1, efc[i]);
`endif
      model_update(i, st, rdy, ka, kb);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit v, int rs, int rt, bit urs, bit urt,
                       bit w, int rd, bit ld, bit hold);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
    id_use_rs = urs; id_use_rt = urt;
    id_wreg = w; id_rd = 5'(rd); id_load = ld; mem_hold = hold;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); step(); reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_clear(i); T[i] = 0; hp[i] = 0;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_exv", 32'(exv0), 0);
    chk("rst_fwd_a", 32'(fa0), 0);

    // ALU chain: add r3; sub r4,r3,r5; then a user of r3 one slot later.
    do_reset();
    drive(1, 1, 2, 1, 1, 1, 3, 0, 0); step();
    drive(1, 3, 5, 1, 1, 1, 4, 0, 0); #1;
    chk("alu_stall", 32'(stall0), 0);
    chk("alu_ready", 32'(ready0), 1);
    step();
    chk("alu_fwd_a1", 32'(fa0), 1);
    chk("alu_fwd_b0", 32'(fb0), 0);
    drive(1, 3, 0, 1, 0, 1, 9, 0, 0); step();
    chk("alu_fwd_a2", 32'(fa0), 2);

    // Load-use, default config.
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 2, 1, 0); step();
    drive(1, 2, 2, 1, 1, 1, 6, 0, 0); #1;
    chk("lu_stall", 32'(stall0), 1);
    chk("lu_ready", 32'(ready0), 0);
    step();
    chk("lu_bubble", 32'(exv0), 0);
    chk("lu_stall_off", 32'(stall0), 0);
    step();
    chk("lu_fwd_a", 32'(fa0), 2);
    chk("lu_fwd_b", 32'(fb0), 2);
    chk("lu_exv", 32'(exv0), 1);

    // Load-use, 4 stages / 2 load delays.
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 7, 1, 0); step();
    drive(1, 7, 0, 1, 0, 1, 8, 0, 0); #1;
    chk("ld2_stall1", 32'(stall1), 1);
    step();
    chk("ld2_stall2", 32'(stall1), 1);
    step();
    chk("ld2_stall3", 32'(stall1), 0);
    chk("ld2_ready", 32'(ready1), 1);
    step();
    chk("ld2_fwd_a", 32'(fa1), 3);

    // Register 0 and unused source.
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 0, 1, 0); step();
    drive(1, 0, 0, 1, 1, 1, 5, 0, 0); #1;
    chk("r0_stall", 32'(stall0), 0);
    step();
    chk("r0_fwd_a", 32'(fa0), 0);
    drive(1, 1, 0, 1, 0, 1, 9, 1, 0); step();
    drive(1, 1, 9, 1, 0, 1, 5, 0, 0); #1;
    chk("unused_stall", 32'(stall0), 0);
    step();
    chk("unused_fwd_b", 32'(fb0), 0);

    // mem_hold during a pending load-use, then mid-stream reset.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 1, 0, 1, 0, 1, 2, 1, 0); step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 2, 2, 1, 1, 1, 6, 0, 1); #1;
      chk("hold_stall", 32'(stall0), 1);
      chk("hold_ready", 32'(ready0), 0);
      step();
      chk("hold_fwd_a", 32'(fa0), 1);
      chk("hold_exv", 32'(exv0), 1);
    end
    drive(1, 2, 2, 1, 1, 1, 6, 0, 0); #1;
    chk("rel_stall", 32'(stall0), 1);
    step();
    chk("rel_ready", 32'(ready0), 1);
    step();
    chk("rel_fwd_a", 32'(fa0), 2);
    drive(1, 1, 0, 1, 0, 1, 3, 1, 0); step();
    reset = 1'b1; idle(); step(); reset = 1'b0;
    chk("mrst_exv", 32'(exv0), 0);
    chk("mrst_fwd_a", 32'(fa0), 0);
    drive(1, 3, 0, 1, 0, 1, 4, 0, 0); #1;
    chk("mrst_stall", 32'(stall0), 0);
    step();

`ifdef HAZARD_PERF_EN
    do_reset();
    for (int r = 0; r < 5; r++) begin
      drive(1, 1, 0, 1, 0, 1, 2, 1, 0); step();
      drive(1, 2, 2, 1, 1, 1, 6, 0, 0); step(); step();
    end
    idle();
    chk("perf_stall_cnt", sc0, 32'd5);
    chk("perf_fwd_cnt", fc0, 32'd5);
`endif

    // Randomized traffic over a small register set to provoke hazards.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 9) < 8,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
